// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a first-word-fall-through synchronous FIFO
module fifo_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = $clog2(FIFO_DEPTH),
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    output logic          o_wen,
    output logic [AW-1:0] o_waddr,
    output logic [AW-1:0] o_raddr,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic [AW:0]   o_count,
    output logic          o_overflow,
    output logic          o_underflow
);
    localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE = (AW+1)'(AE_LEVEL);
    logic [AW:0] wptr, rptr;
    logic        push_ok, pop_ok;
    assign o_empty        = wptr == rptr;
    assign o_full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign o_count        = wptr - rptr;
    assign o_almost_full  = o_count >= AF;
    assign o_almost_empty = o_count <= AE;
    assign o_waddr        = wptr[AW-1:0];
    assign o_raddr        = rptr[AW-1:0];
    assign pop_ok         = i_pop & ~o_empty;
    assign push_ok        = i_push & (~o_full | pop_ok);
    assign o_wen          = push_ok;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            wptr        <= wptr + (AW+1)'(push_ok);
            rptr        <= rptr + (AW+1)'(pop_ok);
            o_overflow  <= i_push & ~push_ok;
            o_underflow <= i_pop & ~pop_ok;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table-driven and scoreboard checks of fifo_ctrl with a bench-side memory
module tb_fifo_ctrl;
    localparam int D  = 8;
    localparam int AW = 3;
    logic          i_clk = 1'b0, i_rst_n = 1'b0, i_push = 1'b0, i_pop = 1'b0;
    logic          o_wen, o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;
    logic [AW-1:0] o_waddr, o_raddr;
    logic [AW:0]   o_count;
    logic [7:0]    mem [D];
    logic [7:0]    wdata = '0;
    logic [7:0]    sb [$];
    int            n_cmp = 0, n_bad = 0, ew = 0, er = 0, ecnt = 0;
    typedef struct {
        logic p, q, w;
        int   c;
        logic o, u;
    } vec_t;
    vec_t vecs [$];

    fifo_ctrl #(.FIFO_DEPTH(D)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(i_push), .i_pop(i_pop),
        .o_wen(o_wen), .o_waddr(o_waddr), .o_raddr(o_raddr),
        .o_full(o_full), .o_empty(o_empty),
        .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
        .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) if (o_wen) mem[o_waddr] <= wdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic post_check(input logic o, input logic u);
        check("count", int'(o_count), ecnt);
        check("full", int'(o_full), int'(ecnt == D));
        check("empty", int'(o_empty), int'(ecnt == 0));
        check("almost_full", int'(o_almost_full), int'(ecnt >= D - 1));
        check("almost_empty", int'(o_almost_empty), int'(ecnt <= 1));
        check("waddr", int'(o_waddr), ew);
        check("raddr", int'(o_raddr), er);
        check("overflow", int'(o_overflow), int'(o));
        check("underflow", int'(o_underflow), int'(u));
    endtask

    task automatic step(input logic p, q, w, input int c, input logic o, u);
        logic pok;
        @(negedge i_clk);
        i_push = p;
        i_pop  = q;
        wdata  = wdata + 8'd1;
        #1;
        check("wen", int'(o_wen), int'(w));
        pok = q && ecnt != 0;
        if (pok) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata: pop with empty scoreboard, got %0d", mem[o_raddr]);
            end else check("rdata", int'(mem[o_raddr]), int'(sb.pop_front()));
        end
        if (w) sb.push_back(wdata);
        ew   = (ew + int'(w)) % D;
        er   = (er + int'(pok)) % D;
        ecnt = c;
        @(posedge i_clk);
        #1;
        post_check(o, u);
    endtask

    function automatic void add(input logic p, q, w, input int c, input logic o, u);
        vec_t v;
        v.p = p; v.q = q; v.w = w; v.c = c; v.o = o; v.u = u;
        vecs.push_back(v);
    endfunction

    initial begin
        add(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= D; i++) add(1, 0, 1, i, 0, 0);
        add(1, 0, 0, D, 1, 0);
        add(0, 0, 0, D, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 1, D, 0, 0);
        for (int i = D - 1; i >= 0; i--) add(0, 1, 0, i, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0);

        #2;
        post_check(0, 0);
        check("rst_wen_idle", int'(o_wen), 0);
        i_push = 1'b1;
        #1;
        check("rst_wen_push", int'(o_wen), 1);
        i_push = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        foreach (vecs[k]) step(vecs[k].p, vecs[k].q, vecs[k].w, vecs[k].c, vecs[k].o, vecs[k].u);

        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 2, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 3, 0, 0);
            step(0, 1, 0, 2, 0, 0);
        end
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        for (int i = 1; i <= 5; i++) step(1, 0, 1, i, 0, 0);
        @(negedge i_clk);
        i_push = 1'b0;
        i_pop  = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        ew = 0; er = 0; ecnt = 0;
        sb.delete();
        post_check(0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
